// File: rtl/data_mem_ctrl_if.sv
// Processor data-memory bus plus host loader port for data_mem_ctrl.
// master: processor / host side, slave: the memory controller.
interface data_mem_ctrl_if #(
    parameter int AW = 8
);
    logic [31:0]   address;
    logic [31:0]   writeData;
    logic          WR;
    logic          MemtoRegOut;
    logic [31:0]   readData;
    logic          stall;
    logic          err;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_we;

    modport master (
        output address, writeData, WR, MemtoRegOut,
        output ld_en, ld_addr, ld_data, ld_we,
        input  readData, stall, err
    );

    modport slave (
        input  address, writeData, WR, MemtoRegOut,
        input  ld_en, ld_addr, ld_data, ld_we,
        output readData, stall, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: word-organised synchronous RAM behind the processor
// load/store port, with a host loader port for preloading image data.
// Loads take two cycles (issue + RD_WAIT) and stall the processor for the
// issue cycle; invalid accesses set a sticky error and return zero.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | accepting processor stores/loads, or entering loader mode
// RD_WAIT   | RAM read in flight, readData captured at the end of the cycle
// LOAD_MODE | host loader owns the RAM, processor held by stall
module data_mem_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_LOAD    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   mem_rd_q;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [AW-1:0] word_idx;
    logic          addr_ok;
    logic          stall_c;

    assign word_idx = bus.address[AW+1:2];
    assign addr_ok  = (bus.address[1:0] == 2'b00) && (bus.address < 32'(DEPTH * 4));

    // Next-state, RAM port control and stall decode
    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = word_idx;
        mem_wdata   = bus.writeData;
        stall_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.ld_en) begin
                    // The processor access is dropped this cycle, so hold it.
                    state_d = S_LOAD;
                    stall_c = 1'b1;
                end else if (bus.WR) begin
                    if (addr_ok) begin
                        mem_we = 1'b1;
                    end else begin
                        read_data_d = 32'd0;
                    end
                    if (!addr_ok || bus.MemtoRegOut) begin
                        err_d = 1'b1;
                    end
                end else if (bus.MemtoRegOut) begin
                    if (addr_ok) begin
                        mem_re  = 1'b1;
                        stall_c = 1'b1;
                        state_d = S_RD_WAIT;
                    end else begin
                        err_d       = 1'b1;
                        read_data_d = 32'd0;
                    end
                end
            end
            S_RD_WAIT: begin
                read_data_d = mem_rd_q;
                state_d     = bus.ld_en ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                if (bus.ld_en) begin
                    stall_c = 1'b1;
                    if (bus.ld_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.ld_addr;
                        mem_wdata = bus.ld_data;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            read_data_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
        end
    end

    // RAM array with registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rd_q <= mem[word_idx];
        end
    end

    assign bus.readData = read_data_q;
    assign bus.err      = err_q;
    assign bus.stall    = stall_c & ~rst;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios followed by
// randomized loads, stores and loader bursts against a word-array model.
// Load results are pushed on issue and checked by an independent monitor.
module tb_data_mem_ctrl;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.AW(AW)) bus ();
    data_mem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [DEPTH];
    logic        model_err;
    logic [31:0] model_rd;
    logic [31:0] exp_q [$];
    int          pending  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
    endfunction

    // Monitor: a load seen issuing (stall with a plain load request) delivers
    // readData two edges later; reset discards anything in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
            end else begin
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL load_result actual=%h required=<no pending load>", bus.readData);
                        end else begin
                            chk("load_result", bus.readData, exp_q.pop_front());
                        end
                    end
                end
                if (bus.stall && bus.MemtoRegOut && !bus.WR && !bus.ld_en) pending = 2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.address     = 32'd0;
        bus.writeData   = 32'd0;
        bus.WR          = 1'b0;
        bus.MemtoRegOut = 1'b0;
        bus.ld_en       = 1'b0;
        bus.ld_we       = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = 32'd0;
    endtask

    task automatic ld_begin();
        bus.ld_en = 1'b1;
        bus.ld_we = 1'b0;
        tick();
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [31:0] d);
        bus.ld_we   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        #1 chk("loader_stall", 32'(bus.stall), 32'd1);
        tick();
        model_mem[a] = d;
    endtask

    task automatic ld_end();
        bus.ld_we = 1'b0;
        bus.ld_en = 1'b0;
        #1 chk("loader_exit_stall", 32'(bus.stall), 32'd0);
        tick();
    endtask

    task automatic do_load(input logic [31:0] a);
        logic [31:0] idx;
        idx = a >> 2;
        bus.address     = a;
        bus.WR          = 1'b0;
        bus.MemtoRegOut = 1'b1;
        #1;
        if (addr_valid(a)) begin
            chk("load_stall_issue", 32'(bus.stall), 32'd1);
            model_rd = model_mem[idx[AW-1:0]];
            exp_q.push_back(model_rd);
            tick();
            #1 chk("load_stall_wait", 32'(bus.stall), 32'd0);
            tick();
            bus.MemtoRegOut = 1'b0;
        end else begin
            chk("bad_load_nostall", 32'(bus.stall), 32'd0);
            tick();
            bus.MemtoRegOut = 1'b0;
            model_err = 1'b1;
            model_rd  = 32'd0;
            #1 chk("bad_load_rd", bus.readData, 32'd0);
        end
        chk("load_err", 32'(bus.err), 32'(model_err));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic both);
        logic [31:0] idx;
        idx = a >> 2;
        bus.address     = a;
        bus.writeData   = d;
        bus.WR          = 1'b1;
        bus.MemtoRegOut = both;
        #1 chk("store_nostall", 32'(bus.stall), 32'd0);
        tick();
        bus.WR          = 1'b0;
        bus.MemtoRegOut = 1'b0;
        if (addr_valid(a)) model_mem[idx[AW-1:0]] = d;
        if (!addr_valid(a) || both) model_err = 1'b1;
        if (!addr_valid(a)) model_rd = 32'd0;
        #1;
        chk("store_err", 32'(bus.err), 32'(model_err));
        chk("store_rd", bus.readData, model_rd);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 24) == 0) begin
            if ($urandom_range(0, 1) == 0)
                a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else
                a = 32'($urandom_range(DEPTH * 4, 32'h0001_FFFF)) & 32'hFFFF_FFFC;
        end else begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
        end
        return a;
    endfunction

    initial begin
        idle_bus();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_err = 1'b0;
        model_rd  = 32'd0;

        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reset_rd", bus.readData, 32'd0);
            chk("reset_stall", 32'(bus.stall), 32'd0);
            chk("reset_err", 32'(bus.err), 32'd0);
            tick();
        end

        ld_begin();
        for (int i = 0; i < DEPTH; i++) ld_write(AW'(i), $urandom());
        ld_write(8'h20, 32'hDEAD_BEEF);
        ld_end();
        do_load(32'h80);

        do_store(32'h84, 32'h1234_5678, 1'b0);
        do_load(32'h84);

        do_load(32'h82);
        do_store(32'h400, 32'hCAFE_F00D, 1'b0);
        do_load(32'h100);
        do_load(32'h0);

        do_load(32'h80);
        do_load(32'h84);

        // reset while a read is in flight
        bus.address     = 32'h84;
        bus.MemtoRegOut = 1'b1;
        tick();
        #1 rst = 1'b1;
        #1;
        chk("rst_rdwait_stall", 32'(bus.stall), 32'd0);
        chk("rst_rdwait_rd", bus.readData, 32'd0);
        chk("rst_rdwait_err", 32'(bus.err), 32'd0);
        bus.MemtoRegOut = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_err = 1'b0;
        model_rd  = 32'd0;
        tick();
        do_load(32'h84);

        for (int n = 0; n < 200; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                ld_begin();
                for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                    ld_write(AW'($urandom_range(0, DEPTH - 1)), $urandom());
                ld_end();
            end else if (r <= 9) begin
                do_load(rand_addr());
            end else if (r <= 18) begin
                do_store(rand_addr(), $urandom(), 1'b0);
            end else begin
                do_store(rand_addr(), $urandom(), 1'b1);
            end
        end

        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory stage directly downstream of the processor's memory interface. It consumes `address`, `writeData`, `WR` and `MemtoRegOut` from the processor and returns `readData`. It wraps a word-organised synchronous RAM that holds image data. Because the RAM has one cycle of read latency, a 1-cycle `stall` is raised on every load. A host loader port fills the RAM with encrypted pixels before the program runs.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM.
- AW, 8, word-index width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  32  processor byte address.
- writeData  in  32  processor store data.
- WR  in  1  processor store request.
- MemtoRegOut  in  1  processor load request.
- readData  out  32  load result to the processor.
- stall  out  1  processor must hold PC and the current instruction while high.
- err  out  1  sticky access-error flag.
- ld_en  in  1  host loader owns the RAM.
- ld_addr  in  AW  host word index.
- ld_data  in  32  host write data.
- ld_we  in  1  host write strobe.

Behaviour:
- Reset (asynchronous, immediate):
  - readData=0, stall=0, err=0, FSM state=IDLE.
  - RAM contents are not cleared.
- Address decode:
  - word index = address[AW+1:2].
  - Access is valid only if address[1:0]==0 and address < DEPTH*4.
- FSM states: IDLE, RD_WAIT, LOAD_MODE.
- IDLE:
  - ld_en=1 → LOAD_MODE. No processor access is performed that cycle.
  - WR=1 and valid → RAM[index] <= writeData at this edge. Stay in IDLE, stall=0.
  - MemtoRegOut=1 (WR=0) and valid → issue RAM read; stall=1 combinationally this cycle; → RD_WAIT.
  - WR and MemtoRegOut both 1 → treated as a store; err set.
  - Invalid address with WR or MemtoRegOut → no RAM access, err <= 1, readData <= 0, no stall, stay in IDLE.
- RD_WAIT:
  - readData <= RAM output; stall=0; → IDLE.
  - The processor samples readData at the end of this cycle, so load latency is 2 cycles total.
  - Requests presented while in RD_WAIT are ignored; the processor re-presents them because it is held.
- LOAD_MODE:
  - stall=1 continuously.
  - ld_we=1 → RAM[ld_addr] <= ld_data each cycle.
  - ld_en=0 → IDLE, with stall dropping in that same cycle.
  - Processor WR and MemtoRegOut are ignored.
- ld_en rising while in RD_WAIT: the read completes first, then → LOAD_MODE on the next cycle.
- stall is combinational from state and the inputs above; there is no glitch requirement beyond single-clock timing.
- readData holds its last load value until the next completed load, an invalid access (→0), or reset.
- err is cleared only by rst.
- Reset asserted in RD_WAIT or LOAD_MODE:
  - FSM goes to IDLE and stall=0 immediately.
  - A pending read is discarded.
  - A write coinciding with the reset edge is not guaranteed.

Test Plan:
- rst pulse, then idle 3 cycles → readData=0, stall=0, err=0 throughout.
- Loader: ld_en=1, ld_we=1, write ld_addr=0x20 with 0xDEADBEEF; drop ld_en; processor load at address 0x80 → stall=1 for exactly one cycle, then readData=0xDEADBEEF, stall=0.
- Store address=0x84, writeData=0x12345678, WR=1 for one cycle; then load 0x84 → readData=0x12345678 after one stall cycle, err=0.
- Misaligned load 0x82, then out-of-range store 0x400 (DEPTH=256) → err=1 sticky, readData=0, no stall, RAM word 0x100>>2 unchanged on readback.
- Back-to-back loads 0x80 then 0x84 → two single-cycle stalls, readData updates to each word in order.
- Assert rst during RD_WAIT → stall and readData drop to 0 immediately; next load behaves normally.
